// File: rtl/param_data_memory.sv
// ----------------------------------------------------------------------------
// param_data_memory
//   Byte-enabled data memory with a fixed, parameterised access latency.
//   It is meant to sit behind a CPU that stalls on busywait.
//
//   A request is one of read/write held high. It is accepted on an IDLE edge,
//   and the request fields are latched at that point. The access completes
//   exactly LATENCY rising edges later. The block then spends one DONE cycle
//   with busywait low, so that the CPU can advance, and returns to IDLE.
//   If read and write are both high in IDLE, no access is made and error
//   pulses for one cycle.
//
//   Parameters
//     ADDR_WIDTH : word-address width, depth = 2**ADDR_WIDTH words
//     WORD_BYTES : bytes per word, data width = 8*WORD_BYTES
//     LATENCY    : edges from acceptance to completion (1..255)
//
//   Ports
//     clock      : single clock, rising edge
//     reset_n    : asynchronous active-low reset
//     read/write : request levels
//     address    : word address (wraps naturally)
//     writedata  : little-endian write word, byte k = [8k+7:8k]
//     byteenable : per-byte write mask
//     readdata   : last completed read word
//     busywait   : stall request to the CPU
//     error      : one-cycle pulse for read+write together
//
//   Configuration macro
//     DMEM_RESET_CLEAR_EN : when defined, reset also clears every memory
//                           byte. When undefined, memory contents survive
//                           reset.
// ----------------------------------------------------------------------------
module param_data_memory #(
    parameter int ADDR_WIDTH = 6,
    parameter int WORD_BYTES = 4,
    parameter int LATENCY    = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      read,
    input  logic                      write,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [8*WORD_BYTES-1:0]   writedata,
    input  logic [WORD_BYTES-1:0]     byteenable,
    output logic [8*WORD_BYTES-1:0]   readdata,
    output logic                      busywait,
    output logic                      error
);

    localparam int DW    = 8 * WORD_BYTES;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DW-1:0]           wdata_q, wdata_d;
    logic [WORD_BYTES-1:0]   be_q, be_d;
    logic [DW-1:0]           readdata_q, readdata_d;
    logic                    error_q, error_d;
    logic                    mem_we;
    logic                    req_valid;

    logic [DW-1:0]           mem_q [DEPTH];

    assign req_valid = read ^ write;
    assign readdata  = readdata_q;
    assign error     = error_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        readdata_d = readdata_q;
        error_d    = 1'b0;
        mem_we     = 1'b0;
        busywait   = 1'b0;
        case (state_q)
            IDLE: begin
                // The stall is raised combinationally, so that the CPU holds
                // its request in the same cycle it presents it.
                busywait = req_valid;
                if (req_valid) begin
                    op_wr_d = write;
                    addr_d  = address;
                    wdata_d = writedata;
                    be_d    = byteenable;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = BUSY;
                end else if (read && write) begin
                    error_d = 1'b1;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Completion edge: the only point where memory or
                    // readdata change. This keeps writes atomic.
                    state_d = DONE;
                    if (op_wr_q) mem_we = 1'b1;
                    else         readdata_d = mem_q[addr_q];
                end
            end
            DONE: begin
                // A request held through DONE is seen again only in IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            readdata_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            readdata_q <= readdata_d;
            error_q    <= error_d;
        end
    end

    // mem_we depends on state_q, and reset forces state_q to IDLE.
    // A write that is aborted by reset therefore never reaches the array.
`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            for (int k = 0; k < WORD_BYTES; k++)
                if (be_q[k]) mem_q[addr_q][8*k +: 8] <= wdata_q[8*k +: 8];
        end
    end
`else
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int k = 0; k < WORD_BYTES; k++)
                if (be_q[k]) mem_q[addr_q][8*k +: 8] <= wdata_q[8*k +: 8];
        end
    end
`endif

endmodule

// File: tb/tb_param_data_memory.sv
module tb_param_data_memory;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // u0: default configuration (6-bit address, 4 bytes, latency 5)
    logic        rd0, wr0, bw0, err0;
    logic [5:0]  addr0;
    logic [31:0] wdata0, rdata0;
    logic [3:0]  be0;

    // u1: 8-bit address, 8 bytes, latency 1
    logic        rd1, wr1, bw1, err1;
    logic [7:0]  addr1;
    logic [63:0] wdata1, rdata1;
    logic [7:0]  be1;

    param_data_memory u0 (
        .clock(clock), .reset_n(reset_n), .read(rd0), .write(wr0),
        .address(addr0), .writedata(wdata0), .byteenable(be0),
        .readdata(rdata0), .busywait(bw0), .error(err0));

    param_data_memory #(.ADDR_WIDTH(8), .WORD_BYTES(8), .LATENCY(1)) u1 (
        .clock(clock), .reset_n(reset_n), .read(rd1), .write(wr1),
        .address(addr1), .writedata(wdata1), .byteenable(be1),
        .readdata(rdata1), .busywait(bw1), .error(err1));

    // Each completed access pushes the expected readdata (held for writes)
    // and the expected acceptance-to-completion edge count (-1 = aborted).
    typedef struct {
        logic [63:0] data;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rd_m0;
    logic [63:0] rd_m1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: a busywait run ends in a completion (or an abort). Run length
    // in sampled cycles = the IDLE request cycle + the BUSY cycles, so the
    // number of edges from acceptance to completion is run-1.
    int run0 = 0;
    always @(negedge clock) begin
        exp_t e;
        if (bw0) run0++;
        else if (run0 > 0) begin
            if (q0.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL u0_unexpected_completion: got run %0d expected none", run0);
            end else begin
                e = q0.pop_front();
                check("u0_readdata", {32'h0, rdata0}, e.data);
                if (e.lat >= 0) check("u0_latency", 64'(run0 - 1), 64'(e.lat));
            end
            run0 = 0;
        end
    end

    int run1 = 0;
    always @(negedge clock) begin
        exp_t e;
        if (bw1) run1++;
        else if (run1 > 0) begin
            if (q1.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL u1_unexpected_completion: got run %0d expected none", run1);
            end else begin
                e = q1.pop_front();
                check("u1_readdata", rdata1, e.data);
                if (e.lat >= 0) check("u1_latency", 64'(run1 - 1), 64'(e.lat));
            end
            run1 = 0;
        end
    end

    task automatic wait_done(input bit which);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clock);
            if (which ? !bw1 : !bw0) break;
        end
        if (n == 300) begin
            vectors++; miscompares++;
            $display("FAIL timeout_u%0d: got busywait stuck expected release", which);
        end
        @(posedge clock); #1;
    endtask

    task automatic access0(input bit is_wr, input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] exp_rd);
        exp_t e;
        e.data = {32'h0, exp_rd}; e.lat = 5;
        q0.push_back(e);
        rd_m0 = exp_rd;
        rd0 = !is_wr; wr0 = is_wr; addr0 = a; wdata0 = d; be0 = be;
        @(posedge clock); #1;
        // Scrambled inputs during BUSY must be ignored.
        rd0 = 1'b0; wr0 = 1'b0; addr0 = ~a; wdata0 = ~d; be0 = ~be;
        wait_done(1'b0);
    endtask

    task automatic access1(input bit is_wr, input logic [7:0] a, input logic [63:0] d,
                           input logic [7:0] be, input logic [63:0] exp_rd);
        exp_t e;
        e.data = exp_rd; e.lat = 1;
        q1.push_back(e);
        rd_m1 = exp_rd;
        rd1 = !is_wr; wr1 = is_wr; addr1 = a; wdata1 = d; be1 = be;
        @(posedge clock); #1;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = ~a; wdata1 = ~d; be1 = ~be;
        wait_done(1'b1);
    endtask

    initial begin
        exp_t e;
        reset_n = 1'b0;
        rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0; be0 = '0;
        rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0; be1 = '0;
        rd_m0 = '0; rd_m1 = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_readdata0", {32'h0, rdata0}, 64'h0);
        check("reset_busywait0", {63'h0, bw0}, 64'h0);
        check("reset_error0", {63'h0, err0}, 64'h0);
        check("reset_readdata1", rdata1, 64'h0);
        @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // Full-word write then read
        access0(1'b1, 6'd3, 32'hDEADBEEF, 4'hF, rd_m0);
        access0(1'b0, 6'd3, 32'h0, 4'h0, 32'hDEADBEEF);

        // Partial byte-enable merge
        access0(1'b1, 6'd7, 32'h11223344, 4'hF, rd_m0);
        access0(1'b1, 6'd7, 32'hAABBCCDD, 4'b0101, rd_m0);
        access0(1'b0, 6'd7, 32'h0, 4'h0, 32'h11BB33DD);

        // Top address with only the top byte enabled on the second write
        access0(1'b1, 6'd63, 32'hCAFEF00D, 4'hF, rd_m0);
        access0(1'b1, 6'd63, 32'h5A000000, 4'b1000, rd_m0);
        access0(1'b0, 6'd63, 32'h0, 4'h0, 32'h5AFEF00D);

        // Illegal read+write: no stall, one-cycle error, nothing touched
        access0(1'b1, 6'd0, 32'hA5A5A5A5, 4'hF, rd_m0);
        rd0 = 1; wr0 = 1; addr0 = 6'd0; wdata0 = 32'h0; be0 = 4'hF;
        @(negedge clock);
        check("err_busywait_low", {63'h0, bw0}, 64'h0);
        check("err_not_yet", {63'h0, err0}, 64'h0);
        @(posedge clock); #1 rd0 = 0; wr0 = 0;
        @(negedge clock);
        check("err_pulse", {63'h0, err0}, 64'h1);
        check("err_busywait_still_low", {63'h0, bw0}, 64'h0);
        @(negedge clock);
        check("err_pulse_end", {63'h0, err0}, 64'h0);
        check("err_readdata_held", {32'h0, rdata0}, {32'h0, rd_m0});
        @(posedge clock); #1;
        access0(1'b0, 6'd0, 32'h0, 4'h0, 32'hA5A5A5A5);

        // Reset at the third edge after acceptance of a pending write
        access0(1'b1, 6'd5, 32'h12345678, 4'hF, rd_m0);
        e.data = 64'h0; e.lat = -1;
        q0.push_back(e);
        wr0 = 1; addr0 = 6'd5; wdata0 = 32'hFFFFFFFF; be0 = 4'hF;
        @(posedge clock); #1 wr0 = 0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0; rd_m0 = '0;
        @(negedge clock);
        check("abort_readdata", {32'h0, rdata0}, 64'h0);
        check("abort_busywait", {63'h0, bw0}, 64'h0);
        check("abort_error", {63'h0, err0}, 64'h0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
`ifdef DMEM_RESET_CLEAR_EN
        access0(1'b0, 6'd5, 32'h0, 4'h0, 32'h0);
        access0(1'b0, 6'd3, 32'h0, 4'h0, 32'h0);
`else
        access0(1'b0, 6'd5, 32'h0, 4'h0, 32'h12345678);
        access0(1'b0, 6'd3, 32'h0, 4'h0, 32'hDEADBEEF);
`endif

        // Wide instance: the extreme addresses must not alias
        access1(1'b1, 8'd255, 64'h0123456789ABCDEF, 8'hFF, rd_m1);
        access1(1'b1, 8'd0,   64'hFEDCBA9876543210, 8'hFF, rd_m1);
        access1(1'b1, 8'd255, 64'h0, 8'h0F, rd_m1);

        // Latency 1, read held high across two accesses
        e.data = 64'h01234567_00000000; e.lat = 1; q1.push_back(e);
        e.data = 64'hFEDCBA9876543210;  e.lat = 1; q1.push_back(e);
        rd1 = 1; addr1 = 8'd255;
        @(posedge clock); #1 addr1 = 8'd0;   // BUSY: the address change is ignored
        @(posedge clock); #1;                // DONE
        @(negedge clock);
        check("l1_done_busywait_low", {63'h0, bw1}, 64'h0);
        @(posedge clock); #1;                // IDLE: the held read is accepted again
        @(posedge clock); #1;                // BUSY
        @(posedge clock); #1 rd1 = 0;        // DONE
        @(posedge clock); #1;

        repeat (3) @(posedge clock);
        check("u0_queue_drained", 64'(q0.size()), 64'h0);
        check("u1_queue_drained", 64'(q1.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, meaning word-address width; depth = 2^ADDR_WIDTH words.
REQ-002 The block SHALL have parameter WORD_BYTES, default 4, meaning bytes per word; data width = 8*WORD_BYTES.
REQ-003 The block SHALL have parameter LATENCY, default 5, meaning clock edges from acceptance to completion; legal range 1..255.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port read, input, 1, read request level.
REQ-007 The block SHALL have port write, input, 1, write request level.
REQ-008 The block SHALL have port address, input, ADDR_WIDTH, word address.
REQ-009 The block SHALL have port writedata, input, 8*WORD_BYTES, little-endian write word; byte k = bits [8k+7:8k].
REQ-010 The block SHALL have port byteenable, input, WORD_BYTES, per-byte write mask.
REQ-011 The block SHALL have port readdata, output, 8*WORD_BYTES, last completed read word.
REQ-012 The block SHALL have port busywait, output, 1, stall request to the CPU.
REQ-013 The block SHALL have port error, output, 1, one-cycle pulse flagging an illegal request.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015 A request SHALL be valid when exactly one of read/write is high.
REQ-016 In IDLE, busywait SHALL be combinationally high whenever the request is valid; in BUSY it SHALL be high; in DONE it SHALL be low.
REQ-017 On an edge in IDLE with a valid request, the block SHALL latch op, address, writedata and byteenable, load the counter with LATENCY-1, and enter BUSY.
REQ-018 In BUSY, inputs SHALL be ignored; the latched copies SHALL be used.
REQ-019 On each BUSY edge with counter nonzero, the counter SHALL decrement.
REQ-020 On the BUSY edge with counter zero, the access SHALL complete and the FSM SHALL enter DONE.
REQ-021 Acceptance to completion SHALL be exactly LATENCY rising edges.
REQ-022 On write completion, each byte k with byteenable[k]=1 SHALL be written; other bytes SHALL be unchanged.
REQ-023 Writes SHALL be atomic; no byte changes before the completion edge.
REQ-024 On read completion, readdata SHALL load the full addressed word; otherwise readdata SHALL hold its value.
REQ-025 DONE SHALL last exactly one cycle, ignore inputs, and return to IDLE.
REQ-026 A request held high through DONE SHALL be re-evaluated only in IDLE.
REQ-027 In IDLE with read and write both high, the block SHALL keep busywait low, perform no access, and pulse error high for one cycle at the next edge.
REQ-028 error SHALL be low in all other cases.
REQ-029 Address SHALL wrap naturally; there is no out-of-range case.

Reset
REQ-030 While reset_n is low, FSM SHALL be IDLE, counter 0, readdata 0, error 0; busywait SHALL follow REQ-016.
REQ-031 Reset asserted during BUSY SHALL abort the access; a pending write SHALL not modify memory.

Configuration
REQ-032 With DMEM_RESET_CLEAR_EN defined, reset SHALL clear every memory byte to 0.
REQ-033 Without DMEM_RESET_CLEAR_EN, memory contents SHALL be preserved across reset; only control state and outputs reset.

Verification
REQ-034 Write 0xDEADBEEF to addr 3 with byteenable 4'hF, then read addr 3 -> busywait high 5 edges each access; readdata = 0xDEADBEEF after read completion.
REQ-035 Write 0x11223344 to addr 7 with byteenable 4'hF, then write 0xAABBCCDD with byteenable 4'b0101, then read addr 7 -> readdata = 0x11BB33DD.
REQ-036 Assert read and write together on addr 0 in IDLE -> busywait stays 0; error pulses 1 cycle; memory and readdata unchanged.
REQ-037 Write 0x12345678 to addr 5, then pull reset_n low at edge 3 of a second write of 0xFFFFFFFF to addr 5 -> after release (macro undefined), read addr 5 returns 0x12345678; with DMEM_RESET_CLEAR_EN it returns 0.
REQ-038 LATENCY=1: back-to-back read requests -> busywait high 1 cycle; DONE cycle low; next read accepted only after DONE.
REQ-039 ADDR_WIDTH=8, WORD_BYTES=8: write to addr 255 and addr 0 with distinct 64-bit values -> both read back intact; no aliasing.
